// File: rtl/out_seq_ctrl.sv
// Output sequencer for the accumulator bank: queues kernel-window completions and
// emits, for each one, a swap pulse followed by a back-pressured burst of result addresses.
module out_seq_ctrl #(
    parameter int CH_W  = 4,
    parameter int SP_W  = 10,
    parameter int A_W   = 12,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_init,
    input  logic            k_fin,
    input  logic [CH_W-1:0] od,
    input  logic [SP_W-1:0] os,
    input  logic            mode,
    input  logic [A_W-1:0]  base,
    input  logic            o_ready,
    output logic            update,
    output logic            outr,
    output logic [A_W-1:0]  oa,
    output logic            out_busy,
    output logic            ovf,
    output logic            done
);
    localparam int PC_W = $clog2(DEPTH + 1);
    localparam int P_W  = CH_W + SP_W;

    typedef enum logic [1:0] {IDLE, START, BURST} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [CH_W-1:0] ct, ct_nxt;
    logic [SP_W-1:0] wi, wi_nxt;
    logic            mode_q, mode_nxt;
    logic            ovf_nxt, done_nxt;

    logic            accept, dec, full, take;
    logic [CH_W:0]   nch;
    logic [P_W-1:0]  lin;

    assign accept = (state == BURST) && o_ready;
    assign dec    = (state == START);
    assign full   = (pc == PC_W'(DEPTH));
    // a START in the same cycle frees a slot, so a k_fin at full is still taken
    assign take   = k_fin && (!full || dec);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ct_nxt    = ct;
        wi_nxt    = wi;
        mode_nxt  = mode_q;
        ovf_nxt   = ovf;
        done_nxt  = 1'b0;

        if (take && !dec)
            pc_nxt = pc + PC_W'(1);
        else if (!take && dec)
            pc_nxt = pc - PC_W'(1);
        if (k_fin && !take)
            ovf_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (pc != '0)
                    state_nxt = START;
            end
            START: begin
                ct_nxt    = '0;
                mode_nxt  = mode;
                state_nxt = BURST;
            end
            BURST: begin
                if (accept) begin
                    ct_nxt = ct + CH_W'(1);
                    if (ct == od) begin
                        ct_nxt = '0;
                        if (wi == os - SP_W'(1)) begin
                            wi_nxt   = '0;
                            done_nxt = 1'b1;
                        end else begin
                            wi_nxt = wi + SP_W'(1);
                        end
                        state_nxt = (pc != '0 || k_fin) ? START : IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (s_init) begin
            state_nxt = IDLE;
            pc_nxt    = '0;
            ct_nxt    = '0;
            wi_nxt    = '0;
            ovf_nxt   = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= '0;
            ct     <= '0;
            wi     <= '0;
            mode_q <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ct     <= ct_nxt;
            wi     <= wi_nxt;
            mode_q <= mode_nxt;
            ovf    <= ovf_nxt;
            done   <= done_nxt;
        end
    end

    // channel count is one bit wider so od=all-ones does not wrap to zero
    assign nch = {1'b0, od} + (CH_W + 1)'(1);
    assign lin = mode_q ? (P_W'(wi) * P_W'(nch) + P_W'(ct))
                        : (P_W'(ct) * P_W'(os) + P_W'(wi));

    assign update   = (state == START);
    assign outr     = (state == BURST);
    assign out_busy = full;
    assign oa       = outr ? (A_W'(lin) + base) : '0;
endmodule

// File: tb/tb_out_seq_ctrl.sv
// Directed and randomized checks of out_seq_ctrl against an address/beat-count model.
module tb_out_seq_ctrl;
    logic        clk, rst, s_init, k_fin, mode, o_ready;
    logic [3:0]  od;
    logic [9:0]  os;
    logic [11:0] base;
    logic        update, outr, out_busy, ovf, done;
    logic [11:0] oa;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int issued;
    int nch;
    logic [11:0] beat_q[$];
    logic        stall_q = 1'b0;
    logic [11:0] stall_oa = '0;

    out_seq_ctrl #(.CH_W(4), .SP_W(10), .A_W(12), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .s_init(s_init), .k_fin(k_fin), .od(od), .os(os),
        .mode(mode), .base(base), .o_ready(o_ready), .update(update), .outr(outr),
        .oa(oa), .out_busy(out_busy), .ovf(ovf), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int a_exp(input int md, input int bs, input int d, input int s,
                                 input int w, input int c);
        return (md != 0) ? (bs + w * (d + 1) + c) % 4096 : (bs + c * s + w) % 4096;
    endfunction

    // beat log, done count, and hold-under-backpressure check
    always @(negedge clk) begin
        if (stall_q && rst)
            chk("stall_hold", {19'd0, outr, oa}, {19'd0, 1'b1, stall_oa});
        stall_q  = rst && outr && !o_ready && !s_init;
        stall_oa = oa;
        if (rst && outr && o_ready) beat_q.push_back(oa);
        if (rst && done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_init();
        s_init = 1'b1;
        step();
        s_init = 1'b0;
    endtask

    // one k_fin into an idle block with o_ready=1: swap at +2, beats from +3
    task automatic run_burst(input int w, input bit last);
        k_fin = 1'b1;
        step();
        k_fin = 1'b0;
        chk("b_upd_early", update, 0);
        step();
        chk("b_update", update, 1);
        chk("b_outr_start", outr, 0);
        for (int c = 0; c <= int'(od); c++) begin
            step();
            chk("b_outr", outr, 1);
            chk("b_oa", oa, a_exp(int'(mode), int'(base), int'(od), int'(os), w, c));
        end
        step();
        chk("b_end_outr", outr, 0);
        chk("b_done", done, last);
    endtask

    initial begin
        rst = 1'b0; s_init = 1'b0; k_fin = 1'b0; mode = 1'b0; o_ready = 1'b1;
        od = 4'd3; os = 10'd4; base = 12'd0;
        step();
        step();
        chk("rst_outs", {26'd0, update, outr, out_busy, ovf, done}, 0);
        chk("rst_oa", oa, 0);
        #2 rst = 1'b1;
        step();

        // single burst, channel-major
        run_burst(0, 1'b0);
        step();
        chk("t1_no_more", update, 0);

        // pixel-major with offset, full pixel sweep then wrap
        pulse_init();
        mode = 1'b1; base = 12'd100;
        for (int i = 0; i < 4; i++) begin
            run_burst(i, i == 3);
            step();
        end
        run_burst(0, 1'b0);

        // back-pressure on the second beat
        pulse_init();
        od = 4'd1; mode = 1'b0; base = 12'd0;
        k_fin = 1'b1; step(); k_fin = 1'b0; step(); step();
        chk("t3_b0", oa, 0);
        step();
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) o_ready = 1'b1;
            chk("t3_outr", outr, 1);
            chk("t3_oa", oa, 4);
            if (i < 3) step();
        end
        step();
        chk("t3_end", outr, 0);

        // queue fill and overflow while the downstream stalls
        pulse_init();
        od = 4'd3; o_ready = 1'b0;
        beat_q.delete();
        k_fin = 1'b1; step(); k_fin = 1'b0; step(); step(); step();
        k_fin = 1'b1;
        step(); chk("t4_busy1", out_busy, 0);
        step(); chk("t4_busy2", out_busy, 1); chk("t4_ovf0", ovf, 0);
        step(); chk("t4_ovf1", ovf, 1);
        step(); k_fin = 1'b0; o_ready = 1'b1;
        for (int n = 0; n < 100 && beat_q.size() < 12; n++) step();
        step();
        chk("t4_beats", beat_q.size(), 12);
        chk("t4_ovf_sticky", ovf, 1);
        chk("t4_busy_end", out_busy, 0);
        pulse_init();
        chk("t4_ovf_clr", ovf, 0);

        // k_fin on the last beat with an empty queue
        k_fin = 1'b1; step(); k_fin = 1'b0; step(); step(); step(); step(); step();
        k_fin = 1'b1;
        step();
        k_fin = 1'b0;
        chk("t5_update", update, 1);
        chk("t5_gap_outr", outr, 0);
        step();
        chk("t5_outr", outr, 1);
        chk("t5_oa", oa, a_exp(0, 0, 3, 4, 1, 0));
        for (int n = 0; n < 5; n++) step();

        // s_init abort mid-burst
        pulse_init();
        base = 12'd5;
        run_burst(0, 1'b0);
        k_fin = 1'b1; step(); k_fin = 1'b0; step(); step(); step(); step();
        chk("t6_ct2", oa, a_exp(0, 5, 3, 4, 1, 2));
        s_init = 1'b1;
        step();
        s_init = 1'b0;
        chk("t6_outr", outr, 0);
        chk("t6_ovf", ovf, 0);
        step();
        chk("t6_quiet", {30'd0, update, outr}, 0);
        run_burst(0, 1'b0);

        // async reset mid-burst
        k_fin = 1'b1; step(); k_fin = 1'b0; step(); step(); step();
        chk("t6_pre_rst", outr, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_outs", {26'd0, update, outr, out_busy, ovf, done}, 0);
        chk("t6_rst_oa", oa, 0);
        #1 rst = 1'b1;
        step();

        // randomized rounds against the address/beat model
        for (int r = 0; r < 3; r++) begin
            mode = 1'($urandom_range(0, 1));
            base = 12'($urandom_range(0, 4095));
            case (r)
                0: begin od = 4'($urandom_range(0, 3)); os = 10'($urandom_range(1, 5)); end
                1: begin od = 4'd0; os = 10'd1; end
                default: begin od = 4'd15; os = 10'($urandom_range(2, 4)); mode = 1'b1; base = 12'd4090; end
            endcase
            nch = int'(od) + 1;
            o_ready = 1'b1;
            pulse_init();
            beat_q.delete();
            done_cnt = 0;
            issued = 0;
            for (int n = 0; n < 300; n++) begin
                o_ready = ($urandom_range(0, 3) != 0);
                k_fin = 1'b0;
                if (issued - beat_q.size() / nch < 2 && $urandom_range(0, 2) == 0) begin
                    k_fin = 1'b1;
                    issued++;
                end
                step();
            end
            k_fin = 1'b0;
            o_ready = 1'b1;
            for (int n = 0; n < 2000 && beat_q.size() < issued * nch; n++) step();
            step();
            step();
            chk("rnd_beats", beat_q.size(), issued * nch);
            chk("rnd_done", done_cnt, issued / int'(os));
            chk("rnd_ovf", ovf, 0);
            for (int i = 0; i < beat_q.size(); i++)
                chk("rnd_oa", beat_q[i], a_exp(int'(mode), int'(base), int'(od), int'(os),
                                               (i / nch) % int'(os), i % nch));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
